// File: rtl/cpu_exc_pkg.sv
// ----------------------------------------------------------------------------
// cpu_exc_pkg
// Shared definitions for the CPU exception path:
//   - cause encodings reported to the host (CAUSE_NONE/ILLEGAL/OVF)
//   - the legal opcode set and a reusable legal-opcode check
//   - the halt controller FSM state enum
// ----------------------------------------------------------------------------
package cpu_exc_pkg;

    // Exception cause encodings (2'b11 is reserved and never produced)
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_OVF     = 2'b10;

    // Legal opcode set
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'hB;
    localparam logic [3:0] OP_BR   = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hF;

    // Halt controller states
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_HALTED = 2'd2,
        ST_RESUME = 2'd3
    } halt_state_e;

    // Returns 1 when the opcode belongs to the legal set
    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            OP_NOP, OP_ADD, OP_SUB, OP_AND,
            OP_LD,  OP_ST,  OP_BR,  OP_JMP: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/exc_flush_timer.sv
// ----------------------------------------------------------------------------
// exc_flush_timer
// Loadable 4-bit down-counter used to time the pipeline flush window.
// Ports:
//   clk, rst_n     clock / asynchronous active-low reset
//   load_i         load load_val_i into the counter (has priority over dec_i)
//   load_val_i     value to load
//   dec_i          decrement by one (holds at zero)
//   done_o         counter is zero
// ----------------------------------------------------------------------------
module exc_flush_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    output logic       done_o
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // Next-count selection: load wins, decrement saturates at zero
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == 4'd0);

endmodule

// File: rtl/halt_ctrl.sv
// ----------------------------------------------------------------------------
// halt_ctrl
// Exception responder for the CPU pipeline. Accepts illegal-opcode (decode)
// and overflow (execute) events while running, latches cause and faulting PC,
// flushes the pipeline for FLUSH_CYCLES cycles, then parks the core until the
// host completes a resume_req/resume_ack handshake.
// Ports:
//   clk, rst_n                  clock / asynchronous active-low reset
//   id_valid, id_opcode, id_pc  decode-stage instruction
//   ex_overflow, ex_pc          execute-stage overflow and its PC
//   resume_req                  host resume request (level, held until ack)
//   stall, flush, halted        pipeline control / status (registered)
//   resume_ack                  one-cycle resume acknowledge (registered)
//   cause, epc, exc_count       exception record and saturating counter
// ----------------------------------------------------------------------------
module halt_ctrl
    import cpu_exc_pkg::*;
#(
    parameter int PC_W         = 16,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [3:0]      id_opcode,
    input  logic [PC_W-1:0] id_pc,
    input  logic            ex_overflow,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            resume_req,
    output logic            stall,
    output logic            flush,
    output logic            halted,
    output logic            resume_ack,
    output logic [1:0]      cause,
    output logic [PC_W-1:0] epc,
    output logic [7:0]      exc_count
);

    // Counter is loaded with one less than the window length because the
    // first FLUSH cycle is the load cycle itself.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    halt_state_e     state_q, state_d;
    logic [1:0]      cause_q, cause_d;
    logic [PC_W-1:0] epc_q, epc_d;
    logic [7:0]      count_q, count_d;
    logic            stall_q, flush_q, halted_q, ack_q;

    logic            illegal_op_s;
    logic            event_s;
    logic            tmr_load_s;
    logic            tmr_dec_s;
    logic            tmr_done_s;

    assign illegal_op_s = id_valid & ~is_legal_op(id_opcode);
    assign event_s      = illegal_op_s | ex_overflow;

    exc_flush_timer u_flush_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load_s),
        .load_val_i (FLUSH_LOAD),
        .dec_i      (tmr_dec_s),
        .done_o     (tmr_done_s)
    );

    // Next-state and exception-record update
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        count_d    = count_q;
        tmr_load_s = 1'b0;
        tmr_dec_s  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (event_s) begin
                    state_d    = ST_FLUSH;
                    tmr_load_s = 1'b1;
                    // Overflow belongs to the older instruction, so it wins
                    if (ex_overflow) begin
                        cause_d = CAUSE_OVF;
                        epc_d   = ex_pc;
                    end else begin
                        cause_d = CAUSE_ILLEGAL;
                        epc_d   = id_pc;
                    end
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end else begin
                        count_d = count_q;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (tmr_done_s) begin
                    state_d = ST_HALTED;
                end else begin
                    tmr_dec_s = 1'b1;
                end
            end
            ST_HALTED: begin
                if (resume_req) begin
                    state_d = ST_RESUME;
                    cause_d = CAUSE_NONE;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            ST_RESUME: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State, exception record and registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            cause_q  <= CAUSE_NONE;
            epc_q    <= '0;
            count_q  <= 8'd0;
            stall_q  <= 1'b0;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            count_q  <= count_d;
            stall_q  <= (state_d != ST_RUN);
            flush_q  <= (state_d == ST_FLUSH);
            halted_q <= (state_d == ST_HALTED);
            ack_q    <= (state_d == ST_RESUME);
        end
    end

    assign stall      = stall_q;
    assign flush      = flush_q;
    assign halted     = halted_q;
    assign resume_ack = ack_q;
    assign cause      = cause_q;
    assign epc        = epc_q;
    assign exc_count  = count_q;

endmodule

// File: doc/halt_ctrl.md
# halt_ctrl

Exception responder for the CPU pipeline. It consumes the illegal-opcode and overflow events raised by the decode/execute checks and latches the cause and faulting PC. It then sequences a fixed-length pipeline flush and holds the core halted until the host issues a resume handshake. It sits between the exception detectors and the pipeline control (stall/flush) plus host debug interface.

## Interface
- PC_W, 16, width of program counter values
- FLUSH_CYCLES, 3, number of cycles flush is asserted (legal range 1..15)
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode stage holds a real instruction this cycle
- id_opcode  in  4  opcode in decode
- id_pc  in  PC_W  PC of instruction in decode
- ex_overflow  in  1  execute-stage arithmetic overflow this cycle
- ex_pc  in  PC_W  PC of instruction in execute
- resume_req  in  1  host request to leave halt, level, held until ack
- stall  out  1  freeze fetch/decode/execute
- flush  out  1  squash in-flight pipeline registers
- halted  out  1  core is parked, waiting for resume
- resume_ack  out  1  one-cycle pulse acknowledging resume_req
- cause  out  2  00 none, 01 illegal opcode, 10 overflow, 11 reserved (never driven)
- epc  out  PC_W  PC of faulting instruction
- exc_count  out  8  number of accepted exceptions since reset, saturates at 255

## Operation
- Legal opcodes: 4'h0, 4'h4, 4'h5, 4'h6, 4'h8, 4'hB, 4'hC, 4'hF. illegal_op = id_valid & opcode not in set.
- Event = illegal_op | ex_overflow. Overflow has priority: it belongs to the older instruction, so cause=10 and epc=ex_pc when both fire.
- FSM states: RUN, FLUSH, HALTED, RESUME.
  - RUN: stall=flush=halted=0. On an event: latch cause/epc, increment exc_count, load flush counter with FLUSH_CYCLES-1, go to FLUSH.
  - FLUSH: stall=1, flush=1. Counter decrements each cycle. At 0, go to HALTED.
  - HALTED: stall=1, halted=1. On resume_req=1, go to RESUME.
  - RESUME: stall=1, resume_ack=1, cause cleared to 00. epc is retained. Go to RUN.
- Events outside RUN are ignored: no cause/epc overwrite, no count increment.
- resume_req outside HALTED is ignored. A request held from FLUSH is honoured on entry to HALTED.
- Reset, from any state including mid-flush: state=RUN, all outputs 0, cause=00, epc=0, exc_count=0, flush counter=0.

## Timing
- Event sampled at edge T. From T+1: state FLUSH, stall=flush=1, cause/epc/exc_count updated.
- flush is high for exactly FLUSH_CYCLES cycles (T+1 .. T+FLUSH_CYCLES).
- halted is high from T+FLUSH_CYCLES+1.
- resume_req sampled high in HALTED at edge R. Cycle R+1: RESUME, resume_ack=1, halted=0, stall=1. Cycle R+2: RUN, stall=0.
- Minimum event-to-run turnaround is FLUSH_CYCLES+2 cycles.
- Back-to-back exceptions: an event in the first RUN cycle after RESUME is accepted normally.
- exc_count at 255 holds at 255. The FSM still handles the exception.
- All outputs are registered. No combinational input-to-output path.

## Structure
- Shared package cpu_exc_pkg holds:
  - cause encodings CAUSE_NONE, CAUSE_ILLEGAL, CAUSE_OVF
  - opcode constants for the legal set
  - the halt FSM state enum
- A function in the package provides the legal-opcode check, so the decoder can reuse it.
- One sub-module, exc_flush_timer: loadable 4-bit down-counter with a done flag, instantiated once.

## Test plan
- Reset, then id_valid=1, opcode=4'h2, id_pc=16'h0040 → next cycle cause=01, epc=0040, flush high 3 cycles, halted at cycle 4, exc_count=1.
- Same cycle: ex_overflow=1 with ex_pc=16'h0100, and illegal opcode 4'h3 at id_pc=16'h0102 → cause=10, epc=0100.
- id_valid=0 with opcode 4'h2 → no event, stall stays 0. Loop all 16 opcodes with id_valid=1 → exactly 8 accepted exceptions.
- In HALTED, raise resume_req → resume_ack pulses 1 cycle, cause=00, epc retained, stall drops the cycle after. Overflow pulse during FLUSH → cause unchanged, exc_count unchanged.
- Assert rst_n low mid-FLUSH (cycle 2) → outputs zero immediately, without waiting for a clock edge. After release, state RUN.
- 256 overflow/resume cycles → exc_count stays 255, halt sequence still correct on the 256th.
